irq_encoder4x2: RTL and testbench



---
 rtl/enc_pkg.sv | 34 +++
 rtl/prio_enc4.sv | 33 +++
 rtl/irq_encoder4x2.sv | 104 ++++++++++
 tb/tb_irq_encoder4x2.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the sticky-request priority encoder.
// Contents:
//   state_e    - issue FSM states (IDLE: nothing presented, ISSUE: code held for ack)
//   N_REQ      - number of request lines
//   CODE_W     - width of the encoded index
//   onehot2()  - expands an encoded index back into its request bit
//   count_ones() - population count of a request vector
package enc_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot2(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] result;
    result       = '0;
    result[code] = 1'b1;
    return result;
  endfunction

  function automatic logic [CODE_W:0] count_ones(input logic [N_REQ-1:0] vec);
    logic [CODE_W:0] total;
    total = '0;
    for (int i = 0; i < N_REQ; i++) begin
      total = total + {{CODE_W{1'b0}}, vec[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder.
// Parameters:
//   HI_FIRST - 1: bit 3 has highest priority, 0: bit 0 has highest priority
// Ports:
//   req  (in,  4) - vector to encode
//   code (out, 2) - index of the winning bit (0 when req is all zero)
//   any  (out, 1) - at least one bit of req is set
module prio_enc4
  import enc_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    code = '0;
    any  = |req;
    if (HI_FIRST) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) code = CODE_W'(i);
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_encoder4x2.sv
// Sequential 4-to-2 priority encoder with sticky request capture and a
// valid/ack handshake. Request events are collected into a pending register;
// the highest-priority pending index is issued as a code and held until the
// consumer acknowledges it, which clears the serviced bit.
// Parameters:
//   HI_FIRST - 1: bit 3 highest priority, 0: bit 0 highest priority
// Ports:
//   clk     (in,  1) - rising-edge clock
//   rst_n   (in,  1) - synchronous active-low reset
//   en      (in,  1) - capture/issue enable
//   req     (in,  4) - request lines, each high cycle is an event
//   ack     (in,  1) - consumer accepts the current code while valid
//   code    (out, 2) - issued request index
//   valid   (out, 1) - code is valid and awaiting ack
//   pending (out, 4) - sticky request bits
//   multi   (out, 1) - more than one pending bit set
//   dropped (out, 1) - one-cycle pulse: request hit an already-pending bit
module irq_encoder4x2
  import enc_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending,
  output logic              multi,
  output logic              dropped
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic                multi_q, multi_d;
  logic                dropped_q, dropped_d;
  logic [N_REQ-1:0]    clr;
  logic [CODE_W-1:0]   prio_code;
  logic                prio_any;

  prio_enc4 #(
    .HI_FIRST(HI_FIRST)
  ) u_prio (
    .req (pending_q),
    .code(prio_code),
    .any (prio_any)
  );

  // Request capture. A new event on a bit that is being cleared this cycle
  // is ORed in after the clear, so it survives as a fresh event and is not
  // reported as dropped.
  always_comb begin
    clr = '0;
    if (state_q == ISSUE && ack) clr = onehot2(code_q);
    pending_d = (pending_q & ~clr) | (en ? req : '0);
    dropped_d = en & (|(req & pending_q & ~clr));
    multi_d   = (count_ones(pending_d) >= (CODE_W + 1)'(2));
  end

  // Issue FSM. The code is loaded only when leaving IDLE, so it stays frozen
  // for the whole ISSUE state regardless of new requests or en.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (en && prio_any) begin
          state_d = ISSUE;
          code_d  = prio_code;
        end
      end
      ISSUE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pending_q <= '0;
      multi_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      multi_q   <= multi_d;
      dropped_q <= dropped_d;
    end
  end

  assign code    = code_q;
  assign valid   = (state_q == ISSUE);
  assign pending = pending_q;
  assign multi   = multi_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_irq_encoder4x2.sv
// Self-checking bench for irq_encoder4x2. Both priority orders are
// instantiated on shared stimulus; the vector table targets the HI_FIRST=1
// instance, a hand-written sequence covers the HI_FIRST=0 instance.
module tb_irq_encoder4x2;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       ack;
    logic [3:0] exp_pending;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic       exp_multi;
    logic       exp_dropped;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       ack;

  logic [1:0] hi_code, lo_code;
  logic       hi_valid, lo_valid;
  logic [3:0] hi_pending, lo_pending;
  logic       hi_multi, lo_multi;
  logic       hi_dropped, lo_dropped;

  int checks;
  int errors;
  vec_t vecs[$];

  irq_encoder4x2 #(.HI_FIRST(1'b1)) dut_hi (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .ack    (ack),
    .code   (hi_code),
    .valid  (hi_valid),
    .pending(hi_pending),
    .multi  (hi_multi),
    .dropped(hi_dropped)
  );

  irq_encoder4x2 #(.HI_FIRST(1'b0)) dut_lo (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .ack    (ack),
    .code   (lo_code),
    .valid  (lo_valid),
    .pending(lo_pending),
    .multi  (lo_multi),
    .dropped(lo_dropped)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic e, input logic [3:0] rq, input logic a,
                        input logic [3:0] p, input logic v, input logic [1:0] c,
                        input logic m, input logic d);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = rq; t.ack = a;
    t.exp_pending = p; t.exp_valid = v; t.exp_code = c;
    t.exp_multi = m; t.exp_dropped = d;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs, clock them in, and settle 1 unit after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] rq, input logic a);
    rst_n = r; en = e; req = rq; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [3:0] act_p, input logic act_v, input logic [1:0] act_c,
                             input logic act_m, input logic act_d,
                             input logic [3:0] exp_p, input logic exp_v, input logic [1:0] exp_c,
                             input logic exp_m, input logic exp_d);
    checks++;
    if (act_p !== exp_p) begin
      errors++;
      $display("[TB] FAIL %s pending got %b expected %b", name, act_p, exp_p);
    end
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s valid got %b expected %b", name, act_v, exp_v);
    end
    checks++;
    if (act_c !== exp_c) begin
      errors++;
      $display("[TB] FAIL %s code got %0d expected %0d", name, act_c, exp_c);
    end
    checks++;
    if (act_m !== exp_m) begin
      errors++;
      $display("[TB] FAIL %s multi got %b expected %b", name, act_m, exp_m);
    end
    checks++;
    if (act_d !== exp_d) begin
      errors++;
      $display("[TB] FAIL %s dropped got %b expected %b", name, act_d, exp_d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    req    = 4'b0000;
    ack    = 1'b0;

    //      rst en  req     ack  pending  v  code multi drop
    // Reset held with all requests high
    addVec(0, 1, 4'b1111, 0, 4'b0000, 0, 2'd0, 0, 0);
    addVec(0, 1, 4'b1111, 0, 4'b0000, 0, 2'd0, 0, 0);
    addVec(0, 1, 4'b1111, 0, 4'b0000, 0, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
    // Priority drain with ack tied high (ack while idle ignored)
    addVec(1, 1, 4'b0101, 1, 4'b0101, 0, 2'd0, 1, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0101, 1, 2'd2, 1, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0001, 0, 2'd2, 0, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0001, 1, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
    // Hold stability: code 1 frozen while bit 3 arrives and en drops
    addVec(1, 1, 4'b0010, 0, 4'b0010, 0, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0010, 1, 2'd1, 0, 0);
    addVec(1, 1, 4'b1000, 0, 4'b1010, 1, 2'd1, 1, 0);
    addVec(1, 1, 4'b0000, 0, 4'b1010, 1, 2'd1, 1, 0);
    addVec(1, 0, 4'b0000, 0, 4'b1010, 1, 2'd1, 1, 0);
    addVec(1, 0, 4'b0000, 1, 4'b1000, 0, 2'd1, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b1000, 1, 2'd3, 0, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0000, 0, 2'd3, 0, 0);
    // Set/clear collision on bit 2
    addVec(1, 1, 4'b0100, 0, 4'b0100, 0, 2'd3, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0100, 1, 2'd2, 0, 0);
    addVec(1, 1, 4'b0100, 1, 4'b0100, 0, 2'd2, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0100, 1, 2'd2, 0, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0000, 0, 2'd2, 0, 0);
    // Drop on pending bit 1, in IDLE and again while issued
    addVec(1, 1, 4'b0010, 0, 4'b0010, 0, 2'd2, 0, 0);
    addVec(1, 1, 4'b0010, 0, 4'b0010, 1, 2'd1, 0, 1);
    addVec(1, 1, 4'b0000, 0, 4'b0010, 1, 2'd1, 0, 0);
    addVec(1, 1, 4'b0010, 0, 4'b0010, 1, 2'd1, 0, 1);
    addVec(1, 1, 4'b0000, 1, 4'b0000, 0, 2'd1, 0, 0);
    // Enable gating: request ignored, then accepted
    addVec(1, 0, 4'b0001, 0, 4'b0000, 0, 2'd1, 0, 0);
    addVec(1, 0, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 0);
    addVec(1, 1, 4'b0001, 0, 4'b0001, 0, 2'd1, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0001, 1, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 0);
    // Pending retained with en low, no issue until en returns
    addVec(1, 1, 4'b0100, 0, 4'b0100, 0, 2'd0, 0, 0);
    addVec(1, 0, 4'b0000, 0, 4'b0100, 0, 2'd0, 0, 0);
    addVec(1, 0, 4'b0010, 0, 4'b0100, 0, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0100, 1, 2'd2, 0, 0);
    addVec(1, 1, 4'b0000, 1, 4'b0000, 0, 2'd2, 0, 0);
    // Reset in the middle of a handshake
    addVec(1, 1, 4'b1011, 0, 4'b1011, 0, 2'd2, 1, 0);
    addVec(1, 1, 4'b0000, 0, 4'b1011, 1, 2'd3, 1, 0);
    addVec(0, 1, 4'b0001, 1, 4'b0000, 0, 2'd0, 0, 0);
    addVec(1, 1, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].ack);
      checkOutput($sformatf("vec%0d", i), hi_pending, hi_valid, hi_code, hi_multi, hi_dropped,
                  vecs[i].exp_pending, vecs[i].exp_valid, vecs[i].exp_code,
                  vecs[i].exp_multi, vecs[i].exp_dropped);
    end

    // Opposite priority orders on the same 1001 burst.
    applyStimulus(0, 1, 4'b0000, 0);
    checkOutput("lo_rst", lo_pending, lo_valid, lo_code, lo_multi, lo_dropped, 4'b0000, 0, 2'd0, 0, 0);
    applyStimulus(1, 1, 4'b1001, 0);
    checkOutput("lo_cap", lo_pending, lo_valid, lo_code, lo_multi, lo_dropped, 4'b1001, 0, 2'd0, 1, 0);
    checkOutput("hi_cap", hi_pending, hi_valid, hi_code, hi_multi, hi_dropped, 4'b1001, 0, 2'd0, 1, 0);
    applyStimulus(1, 1, 4'b0000, 0);
    checkOutput("lo_iss1", lo_pending, lo_valid, lo_code, lo_multi, lo_dropped, 4'b1001, 1, 2'd0, 1, 0);
    checkOutput("hi_iss1", hi_pending, hi_valid, hi_code, hi_multi, hi_dropped, 4'b1001, 1, 2'd3, 1, 0);
    applyStimulus(1, 1, 4'b0000, 1);
    checkOutput("lo_ack1", lo_pending, lo_valid, lo_code, lo_multi, lo_dropped, 4'b1000, 0, 2'd0, 0, 0);
    checkOutput("hi_ack1", hi_pending, hi_valid, hi_code, hi_multi, hi_dropped, 4'b0001, 0, 2'd3, 0, 0);
    applyStimulus(1, 1, 4'b0000, 0);
    checkOutput("lo_iss2", lo_pending, lo_valid, lo_code, lo_multi, lo_dropped, 4'b1000, 1, 2'd3, 0, 0);
    checkOutput("hi_iss2", hi_pending, hi_valid, hi_code, hi_multi, hi_dropped, 4'b0001, 1, 2'd0, 0, 0);
    applyStimulus(1, 1, 4'b0000, 1);
    checkOutput("lo_ack2", lo_pending, lo_valid, lo_code, lo_multi, lo_dropped, 4'b0000, 0, 2'd3, 0, 0);
    checkOutput("hi_ack2", hi_pending, hi_valid, hi_code, hi_multi, hi_dropped, 4'b0000, 0, 2'd0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
